// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial unsigned subtractor (a-b), LSB first, one bit per clock.
// Define SERIAL_SUB_FLAGS_EN to add the registered zero/eq result flags.

module serial_sub_hs (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);
   assign d  = x ^ y;
   assign bo = ~x & y;
endmodule

module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
   ,
   output logic             zero,
   output logic             eq
`endif
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr, b_sr;
   // Only the upper WIDTH-1 result bits are kept; the final bit enters on the last RUN edge.
   logic [WIDTH-2:0] res_sr;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             d1, bo1, d_bit, bo2, br_next;
   logic [WIDTH-1:0] res_next;

   serial_sub_hs u_hs0 (.x(a_sr[0]), .y(b_sr[0]), .d(d1),    .bo(bo1));
   serial_sub_hs u_hs1 (.x(d1),      .y(br),      .d(d_bit), .bo(bo2));

   assign br_next  = bo1 | bo2;
   assign res_next = {d_bit, res_sr};

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
         cnt    <= '0;
         br     <= 1'b0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
         zero   <= 1'b0;
         eq     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               br     <= br_next;
               res_sr <= res_next[WIDTH-1:1];
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  diff  <= res_next;
                  bout  <= br_next;
                  done  <= 1'b1;
                  state <= DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                  zero  <= (res_next == '0);
                  eq    <= (res_next == '0) & ~br_next;
`endif
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl (WIDTH=8): directed cases plus random traffic against
// a transaction-timing reference model (accept edge, done WIDTH edges later).

module tb_serial_sub_ctrl;
   localparam int W = 8;

   logic         clk, rst, start;
   logic [W-1:0] a, b, diff;
   logic         busy, done, bout;
`ifdef SERIAL_SUB_FLAGS_EN
   logic         zero, eq;
`endif

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_FLAGS_EN
      , .zero(zero), .eq(eq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: phase = cycles since acceptance, -1 when idle.
   int           phase = -1;
   logic [W-1:0] m_a, m_b, e_diff;
   logic         e_bout, e_zero, e_eq;
   int           done_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic r);
      start = s; a = av; b = bv; rst = r;
      @(posedge clk);
      if (r) begin
         phase = -1; e_diff = '0; e_bout = 1'b0; e_zero = 1'b0; e_eq = 1'b0;
      end else if (phase < 0) begin
         if (s) begin
            phase = 0; m_a = av; m_b = bv;
         end
      end else if (phase == W) begin
         phase = -1;
      end else begin
         phase++;
         if (phase == W) begin
            e_diff = W'(int'(m_a) - int'(m_b));
            e_bout = (m_a < m_b);
            e_zero = (m_a == m_b);
            e_eq   = (m_a == m_b);
         end
      end
      #1;
      chk("busy", 32'(busy), 32'(phase >= 0));
      chk("done", 32'(done), 32'(phase == W));
      chk("diff", 32'(diff), 32'(e_diff));
      chk("bout", 32'(bout), 32'(e_bout));
`ifdef SERIAL_SUB_FLAGS_EN
      chk("zero", 32'(zero), 32'(e_zero));
      chk("eq",   32'(eq),   32'(e_eq));
`endif
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv);
      cyc(1'b1, av, bv, 1'b0);
      for (int i = 0; i < W + 2; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   initial begin
      e_diff = '0; e_bout = 1'b0; e_zero = 1'b0; e_eq = 1'b0;
      m_a = '0; m_b = '0; done_cnt = 0;
      start = 1'b0; a = '0; b = '0; rst = 1'b1;

      // Reset state
      cyc(1'b0, 8'h00, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 8'h00, 1'b0);

      // Basic subtractions, including borrow, equal and wrap cases
      op(8'h05, 8'h03);
      chk("diff_05_03", 32'(diff), 32'h02);
      op(8'h03, 8'h05);
      chk("diff_03_05", 32'(diff), 32'hFE);
      chk("bout_03_05", 32'(bout), 32'h1);
      op(8'hA7, 8'hA7);
      chk("diff_a7_a7", 32'(diff), 32'h00);
      op(8'h00, 8'h01);
      chk("diff_00_01", 32'(diff), 32'hFF);

      // start ignored while busy (RUN at cycle 3, DONE at cycle 9)
      done_cnt = 0;
      cyc(1'b1, 8'h10, 8'h01, 1'b0);
      for (int i = 1; i < 16; i++)
         cyc((i == 3) || (i == 9), 8'h00, 8'hFF, 1'b0);
      chk("busy_ignore_done_cnt", 32'(done_cnt), 32'd1);
      chk("busy_ignore_diff", 32'(diff), 32'h0F);

      // Reset mid-RUN aborts, then immediate restart
      done_cnt = 0;
      cyc(1'b1, 8'h80, 8'h01, 1'b0);
      for (int i = 1; i < 4; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 8'h00, 1'b1);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_diff", 32'(diff), 32'h00);
      for (int i = 0; i < W + 2; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      op(8'h09, 8'h04);
      chk("restart_diff", 32'(diff), 32'h05);

      // start held high: back-to-back ops every W+2 cycles
      done_cnt = 0;
      for (int i = 0; i < 30; i++) cyc(1'b1, 8'h20, 8'h10, 1'b0);
      chk("b2b_done_cnt", 32'(done_cnt), 32'd3);
      for (int i = 0; i < W + 2; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0);

      // Random traffic with occasional reset; a/b churn every cycle
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 2) == 0, W'($urandom), W'($urandom),
             $urandom_range(0, 59) == 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
